// File: rtl/arm_motion_sequencer.sv
// Three-axis arm motion sequencer: rate-limited stepping of x/y/z
// toward clamped target angles, with servo select rotation.
module arm_motion_sequencer #(
    parameter int unsigned STEP          = 2,
    parameter int unsigned SETTLE_FRAMES = 5,
    parameter int unsigned HOME_X        = 90,
    parameter int unsigned HOME_Y        = 90,
    parameter int unsigned HOME_Z        = 90,
    parameter int unsigned MIN_X         = 3,
    parameter int unsigned MAX_X         = 185,
    parameter int unsigned MIN_Y         = 8,
    parameter int unsigned MAX_Y         = 156,
    parameter int unsigned MIN_Z         = 4,
    parameter int unsigned MAX_Z         = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_x,
    input  logic [7:0] cmd_y,
    input  logic [7:0] cmd_z,
    input  logic       stop,
    output logic       cmd_ready,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [7:0] z,
    output logic [1:0] servo_ctrl,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic signed [8:0] STEP_S = 9'(STEP);
    localparam logic [7:0] STEP_B = 8'(STEP);
    localparam logic [7:0] SET_B  = 8'(SETTLE_FRAMES);
    localparam logic [7:0] HX = 8'(HOME_X);
    localparam logic [7:0] HY = 8'(HOME_Y);
    localparam logic [7:0] HZ = 8'(HOME_Z);
    localparam logic [7:0] LX = 8'(MIN_X);
    localparam logic [7:0] UX = 8'(MAX_X);
    localparam logic [7:0] LY = 8'(MIN_Y);
    localparam logic [7:0] UY = 8'(MAX_Y);
    localparam logic [7:0] LZ = 8'(MIN_Z);
    localparam logic [7:0] UZ = 8'(MAX_Z);

    function automatic logic [7:0] clamp8(
        input logic [7:0] v,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Never overshoots: within one STEP of target, snap to target.
    function automatic logic [7:0] step8(
        input logic [7:0] cur,
        input logic [7:0] tgt
    );
        logic signed [8:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S) return cur + STEP_B;
        if (diff < -STEP_S) return cur - STEP_B;
        return tgt;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [7:0] tx_q, tx_d, ty_q, ty_d, tz_q, tz_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic       done_q, done_d;
    logic       ready_q, busy_q;
    logic [7:0] nx, ny, nz;

    assign nx = step8(x_q, tx_q);
    assign ny = step8(y_q, ty_q);
    assign nz = step8(z_q, tz_q);

    // Next-state: handshake, stepping, settle countdown, stop abort.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        tz_d    = tz_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        sel_d   = sel_q;
        if (frame_tick) begin
            sel_d = (sel_q == 2'b11) ? 2'b01 : sel_q + 2'b01;
        end
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    tx_d    = clamp8(cmd_x, LX, UX);
                    ty_d    = clamp8(cmd_y, LY, UY);
                    tz_d    = clamp8(cmd_z, LZ, UZ);
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (stop) begin
                    tx_d    = x_q;
                    ty_d    = y_q;
                    tz_d    = z_q;
                    state_d = IDLE;
                end else if (frame_tick) begin
                    x_d = nx;
                    y_d = ny;
                    z_d = nz;
                    if (nx == tx_q && ny == ty_q && nz == tz_q) begin
                        state_d = SETTLE;
                        cnt_d   = SET_B;
                    end
                end
            end
            SETTLE: begin
                if (stop) begin
                    tx_d    = x_q;
                    ty_d    = y_q;
                    tz_d    = z_q;
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, home position on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= HX;
            y_q     <= HY;
            z_q     <= HZ;
            tx_q    <= HX;
            ty_q    <= HY;
            tz_q    <= HZ;
            cnt_q   <= 8'd0;
            sel_q   <= 2'b00;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            tz_q    <= tz_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign x          = x_q;
    assign y          = y_q;
    assign z          = z_q;
    assign servo_ctrl = sel_q;

endmodule
